// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer.
//   timer_state_t : controller state encoding (IDLE, RUN, HOLD, DONE)
//   W_DEFAULT     : default width of count / load value / reload register
package timer_pkg;

  localparam int unsigned W_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } timer_state_t;

endpackage

// File: rtl/down_timer_if.sv
// Control/status bundle of the countdown timer.
//   load, load_val, start, stop, periodic : controls driven by the master
//   cnt, busy, tc, done                   : registered status from the timer
// Modports: master (timer user), slave (the timer itself).
interface down_timer_if
  import timer_pkg::*;
#(
  parameter int unsigned w = W_DEFAULT
) ();

  logic         load;
  logic [w-1:0] load_val;
  logic         start;
  logic         stop;
  logic         periodic;
  logic [w-1:0] cnt;
  logic         busy;
  logic         tc;
  logic         done;

  modport master (
    output load, load_val, start, stop, periodic,
    input  cnt, busy, tc, done
  );

  modport slave (
    input  load, load_val, start, stop, periodic,
    output cnt, busy, tc, done
  );

endinterface

// File: rtl/down_timer.sv
// Programmable countdown timer with one-shot and auto-reload modes.
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : down_timer_if.slave
//           load/load_val capture a start value, start/stop run and pause,
//           periodic selects auto-reload; cnt is the current count, busy is
//           high in RUN, tc pulses one cycle per expiry, done is the sticky
//           one-shot completion flag.
// Priority each cycle: reset > load > stop > start > count.
module down_timer
  import timer_pkg::*;
#(
  parameter int unsigned w = W_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  down_timer_if.slave   bus
);

  timer_state_t state;
  logic [w-1:0] cnt_q;
  logic [w-1:0] reload_q;
  logic         busy_q;
  logic         tc_q;
  logic         done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt_q    <= '0;
      reload_q <= '0;
      busy_q   <= 1'b0;
      tc_q     <= 1'b0;
      done_q   <= 1'b0;
    end else if (bus.load) begin
      state    <= IDLE;
      cnt_q    <= bus.load_val;
      reload_q <= bus.load_val;
      busy_q   <= 1'b0;
      tc_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      tc_q <= 1'b0;
      case (state)
        IDLE: begin
          // A zero reload would expire immediately with nothing to count.
          if (bus.start && !bus.stop && reload_q != '0) begin
            state  <= RUN;
            busy_q <= 1'b1;
          end
        end
        HOLD: begin
          if (bus.start && !bus.stop) begin
            state  <= RUN;
            busy_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.start && !bus.stop) begin
            state  <= RUN;
            busy_q <= 1'b1;
            cnt_q  <= reload_q;
            done_q <= 1'b0;
          end
        end
        RUN: begin
          if (bus.stop) begin
            state  <= HOLD;
            busy_q <= 1'b0;
          end else if (cnt_q > w'(1)) begin
            cnt_q <= cnt_q - w'(1);
          end else begin
            // Expiry; cnt==0 in RUN is unreachable but is handled here too so
            // the counter can never underflow.
            tc_q <= 1'b1;
            if (bus.periodic) begin
              cnt_q <= reload_q;
            end else begin
              cnt_q  <= '0;
              done_q <= 1'b1;
              state  <= DONE;
              busy_q <= 1'b0;
            end
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cnt  = cnt_q;
  assign bus.busy = busy_q;
  assign bus.tc   = tc_q;
  assign bus.done = done_q;

endmodule

// File: doc/down_timer.md
Name: down_timer

Overview:
- Programmable countdown timer; the decrementing counterpart of the free-running up counter.
- Loads a start value, counts down by one per clock while running, flags expiry, and supports one-shot and periodic (auto-reload) modes.
- Used for timeouts, tick generation and pacing of other blocks in the same clock domain.

Parameters:
w, 8, width of count, load value and reload register (w >= 2)

Ports:
clk       input   1   system clock, all state updates on rising edge
reset     input   1   synchronous, active-high reset
load      input   1   load load_val into count and reload registers
load_val  input   w   value captured on load
start     input   1   begin or resume counting
stop      input   1   pause counting (hold current count)
periodic  input   1   1 = auto-reload on expiry, 0 = one-shot; sampled every cycle
cnt       output  w   current count (registered)
busy      output  1   high while in RUN
tc        output  1   terminal-count pulse, high exactly one cycle per expiry
done      output  1   sticky one-shot completion flag

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clk, reset).
- Reset: cnt=0, reload=0, state IDLE, busy=0, tc=0, done=0.
- States: IDLE, RUN, HOLD, DONE. busy = (state==RUN). All outputs are registered.
- Priority each cycle: reset > load > stop > start > count.
- load, any state:
  - cnt <= load_val, reload <= load_val, state <= IDLE, done <= 0, tc <= 0.
  - A load during RUN aborts the run.
- start:
  - From IDLE: if reload != 0, go to RUN; cnt is unchanged that edge, and the first decrement occurs on the next edge.
  - From IDLE with reload == 0: ignored, stays IDLE.
  - From HOLD: resume RUN with the current cnt.
  - From DONE: cnt <= reload, done <= 0, go to RUN.
  - In RUN: no effect.
- stop:
  - In RUN: go to HOLD, cnt frozen, tc <= 0.
  - In other states: no effect.
  - stop and start in the same cycle: stop wins.
- RUN with cnt > 1: cnt <= cnt - 1, tc <= 0.
- RUN with cnt == 1:
  - periodic=1: cnt <= reload, tc <= 1, stay in RUN. Period is exactly reload cycles.
  - periodic=0: cnt <= 0, tc <= 1, done <= 1, state <= DONE.
- tc is high only in the cycle immediately after an expiry edge and low on every other cycle. Back-to-back tc is possible only with reload == 1 in periodic mode, where tc stays high continuously.
- Latency from start (IDLE, reload=N) to the tc cycle: N+1 edges, counting the start edge.
- No wrap-around: cnt never decrements below 0 and never underflows to all-ones.
- Changing periodic mid-run takes effect at the next expiry.
- Reset mid-run: all state returns to reset values on that edge, regardless of other inputs.

Decomposition:
- Shared package timer_pkg holds:
  - typedef enum logic [1:0] timer_state_t {IDLE, RUN, HOLD, DONE};
  - a localparam default width of 8.
- No sub-module; a single module with one state register, cnt, reload and registered tc/done.

Test Plan:
- Reset, then load load_val=3 and start, periodic=0 -> cnt after each edge reads 3,2,1,0; tc=1 and done=1 in the cycle cnt=0; busy drops to 0; cnt holds 0 afterwards.
- load 4, periodic=1, start, run 12 cycles -> cnt sequence 4,3,2,1,4,3,2,1,...; tc=1 exactly on each cycle showing the reloaded 4 (every 4 cycles); done stays 0.
- load 10, start, stop after 3 decrements -> cnt frozen at 7 in HOLD for 5 cycles with busy=0; start resumes 6,5,...; tc arrives 7 edges after resume.
- Assert stop and start together in RUN -> goes to HOLD, count frozen; also start with reload=0 after reset -> stays IDLE, busy=0, tc never pulses.
- load 8 mid-run at cnt=2 -> next cycle cnt=8, IDLE, no tc; then start -> 8..0. Also assert reset while cnt=5 in RUN -> next cycle cnt=0, busy=0, done=0.
- From DONE (one-shot, load 2), pulse start -> cnt reloads to 2, done clears, counts 2,1,0 with tc and done again; for w=8, load 255 -> 255 cycles to expiry with no underflow.
